// File: rtl/pipe_skid_stage_if.sv
// pipe_skid_stage_if: valid/ready handshake bundle for pipe_skid_stage.
// Ports: in_valid/in_data/in_ready (upstream side), out_valid/out_data/out_ready
// (downstream side), count (occupancy 0..2). slave = the stage, master = its environment.
interface pipe_skid_stage_if #(parameter int WORD_LENGTH = 32);
    logic                   in_valid;
    logic [WORD_LENGTH-1:0] in_data;
    logic                   in_ready;
    logic                   out_valid;
    logic [WORD_LENGTH-1:0] out_data;
    logic                   out_ready;
    logic [1:0]             count;
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, count
    );
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, count
    );
endinterface

// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: pipeline register with registered in_ready and a 2-entry skid buffer.
// Ports: clk, rst_n (sync active-low), flush (sync discard), bus (slave handshake:
// in_valid/in_data/in_ready, out_valid/out_data/out_ready, count).
module pipe_skid_stage #(
    parameter int WORD_LENGTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    pipe_skid_stage_if.slave      bus
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
    state_t                 state_q, state_d;
    logic [WORD_LENGTH-1:0] main_q, main_d, skid_q, skid_d;
    logic                   in_ready_q, in_ready_d;
    logic                   in_fire, out_fire;
    assign bus.out_valid = state_q != EMPTY;
    assign bus.out_data  = main_q;
    assign bus.in_ready  = in_ready_q;
    assign bus.count     = state_q;
    assign in_fire       = bus.in_valid & in_ready_q;
    assign out_fire      = bus.out_valid & bus.out_ready;
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                state_d = in_fire ? ONE : EMPTY;
                main_d  = in_fire ? bus.in_data : main_q;
            end
            ONE: begin
                state_d = (in_fire & ~out_fire) ? FULL : (~in_fire & out_fire) ? EMPTY : ONE;
                main_d  = (in_fire & out_fire) ? bus.in_data : main_q;
                skid_d  = (in_fire & ~out_fire) ? bus.in_data : skid_q;
            end
            FULL: begin
                state_d = out_fire ? ONE : FULL;
                main_d  = out_fire ? skid_q : main_q;
            end
            default: state_d = EMPTY;
        endcase
        if (flush) begin
            state_d = EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end
        // Registering ready from the next state keeps the upstream ready path flop-driven.
        in_ready_d = state_d != FULL;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end
endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb_pipe_skid_stage: directed and random checks of pipe_skid_stage against a queue model.
module tb_pipe_skid_stage;
    localparam int W = 32;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    always #5 clk = ~clk;
    pipe_skid_stage_if #(.WORD_LENGTH(W)) bus ();
    pipe_skid_stage #(.WORD_LENGTH(W)) dut (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus.slave));
    logic [W-1:0] q[$];
    logic         m_ready = 1'b0;
    int           tests = 0;
    int           fails = 0;
    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic cyc(input logic r, input logic f, input logic iv, input logic [W-1:0] id, input logic ordy);
        logic         prev_v;
        logic [W-1:0] prev_d;
        bit           in_f, out_f;
        rst_n = r;
        flush = f;
        bus.in_valid = iv;
        bus.in_data = id;
        bus.out_ready = ordy;
        prev_v = bus.out_valid;
        prev_d = bus.out_data;
        in_f = iv && m_ready;
        out_f = (q.size() > 0) && ordy;
        @(posedge clk);
        if (!r) begin
            q.delete();
            m_ready = 1'b0;
        end else begin
            if (out_f) void'(q.pop_front());
            if (f) q.delete();
            else if (in_f) q.push_back(id);
            m_ready = q.size() < 2;
        end
        #1;
        chk("out_valid", W'(bus.out_valid), W'(q.size() > 0));
        chk("count", W'(bus.count), W'(q.size()));
        chk("in_ready", W'(bus.in_ready), W'(m_ready));
        if (q.size() > 0) chk("out_data", bus.out_data, q[0]);
        if (r && !f && prev_v && !ordy) chk("stall_stable", bus.out_data, prev_d);
    endtask
    initial begin
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 32'hFF, 1);
        chk("rst_out_valid", W'(bus.out_valid), 0);
        chk("rst_in_ready", W'(bus.in_ready), 0);
        chk("rst_count", W'(bus.count), 0);
        cyc(1, 0, 0, 0, 1);
        chk("rel_in_ready", W'(bus.in_ready), 1);
        for (int i = 1; i <= 8; i++) begin
            cyc(1, 0, 1, W'(i), 1);
            chk("stream_data", bus.out_data, W'(i));
            chk("stream_count", W'(bus.count), 1);
            chk("stream_ready", W'(bus.in_ready), 1);
        end
        cyc(1, 0, 0, 0, 1);
        chk("drain_valid", W'(bus.out_valid), 0);
        cyc(1, 0, 1, 32'hA1, 0);
        cyc(1, 0, 1, 32'hA2, 0);
        cyc(1, 0, 1, 32'hA3, 0);
        chk("bp_count", W'(bus.count), 2);
        chk("bp_ready", W'(bus.in_ready), 0);
        chk("bp_data", bus.out_data, 32'hA1);
        cyc(1, 0, 1, 32'hA3, 1);
        chk("bp_second", bus.out_data, 32'hA2);
        cyc(1, 0, 1, 32'hA3, 1);
        chk("bp_third", bus.out_data, 32'hA3);
        chk("bp_third_count", W'(bus.count), 1);
        cyc(1, 0, 0, 0, 1);
        cyc(1, 0, 1, 32'hB1, 0);
        cyc(1, 0, 1, 32'hB2, 0);
        chk("fl_full", W'(bus.count), 2);
        cyc(1, 1, 1, 32'hB3, 0);
        chk("fl_valid", W'(bus.out_valid), 0);
        chk("fl_count", W'(bus.count), 0);
        chk("fl_ready", W'(bus.in_ready), 1);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 0, 0, 1);
            chk("fl_no_stale", W'(bus.out_valid), 0);
        end
        cyc(1, 0, 1, 32'hC1, 0);
        chk("sim_main", bus.out_data, 32'hC1);
        cyc(1, 0, 1, 32'hC2, 1);
        chk("sim_data", bus.out_data, 32'hC2);
        chk("sim_count", W'(bus.count), 1);
        cyc(1, 0, 0, 0, 1);
        for (int i = 0; i < 10000; i++)
            cyc($urandom_range(0, 199) != 0, $urandom_range(0, 29) == 0,
                1'($urandom), $urandom, $urandom_range(0, 3) != 0 ? 1'($urandom) : 1'b0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
